bird_scene: RTL and testbench



---
 rtl/flappy_pkg.sv | 31 +++
 rtl/lfsr8.sv | 22 ++
 rtl/bird_scene.sv | 186 ++++++++++++++++++
 tb/tb_bird_scene.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared types and constants for the bird game scene.
//   game_state_t : IDLE / PLAY / DEAD
//   COL_*        : 3-bit {r,g,b} colours used by the renderer
//   SCREEN_*     : visible raster size, GROUND_Y is the top row of the ground
//   *_RST        : power-on / round-restart values of the game registers
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } game_state_t;

  localparam logic [2:0] COL_SKY    = 3'b011;
  localparam logic [2:0] COL_BIRD   = 3'b110;
  localparam logic [2:0] COL_PIPE   = 3'b010;
  localparam logic [2:0] COL_GROUND = 3'b100;
  localparam logic [2:0] COL_BLANK  = 3'b000;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int GROUND_Y = 448;

  localparam logic [9:0] BIRD_Y_RST  = 10'd232;
  localparam logic [9:0] PIPE0_X_RST = 10'd640;
  localparam logic [9:0] PIPE1_X_RST = 10'd960;
  localparam logic [9:0] GAP_TOP_RST = 10'd160;
  localparam logic [9:0] GAP_MIN     = 10'd48;
  localparam logic [7:0] LFSR_SEED   = 8'hB4;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 0xB4.
//   clk, n_rst : clock, asynchronous active-low reset
//   en         : advance one step this cycle
//   q          : current register value
module lfsr8
  import flappy_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule

// File: rtl/bird_scene.sv
// Game state and pixel renderer feeding the VGA output stage.
// Game registers advance once per frame on the rising edge of vsync; the
// renderer returns the colour for (x_pos, y_pos) one clock later.
//   clk, n_rst   : pixel clock, asynchronous active-low reset
//   flap         : flap button (synchronous, active high)
//   vsync        : active-high vertical sync
//   x_pos, y_pos : current scan position
//   rgb          : registered {r,g,b} colour
//   score        : pipes passed, saturating at 255
//   game_over    : high while the bird is dead
module bird_scene
  import flappy_pkg::*;
#(
  parameter int BIRD_X   = 160,
  parameter int BIRD_SZ  = 16,
  parameter int PIPE_W   = 40,
  parameter int GAP_H    = 120,
  parameter int SCROLL   = 2,
  parameter int FLAP_VEL = -8,
  parameter int MAX_FALL = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       flap,
  input  logic       vsync,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  output logic [2:0] rgb,
  output logic [7:0] score,
  output logic       game_over
);

  localparam logic signed [4:0]  VEL_FLAP = 5'(FLAP_VEL);
  localparam logic signed [4:0]  VEL_MAX  = 5'(MAX_FALL);
  localparam logic signed [10:0] S_BIRD_SZ = 11'(BIRD_SZ);
  localparam logic signed [10:0] S_GAP_H   = 11'(GAP_H);
  localparam logic signed [10:0] S_GROUND  = 11'(GROUND_Y);

  logic              vsync_d, flap_d, flap_pend;
  logic              frame_tick, flap_rise, flap_eff;
  game_state_t       state;
  logic        [9:0] bird_y;
  logic signed [4:0] vel;
  logic        [9:0] pipe_x  [2];
  logic        [9:0] gap_top [2];
  logic        [7:0] lfsr_q;

  // A press landing in the same cycle as the tick still counts for that tick.
  assign frame_tick = vsync & ~vsync_d;
  assign flap_rise  = flap & ~flap_d;
  assign flap_eff   = flap_pend | flap_rise;

  lfsr8 u_lfsr (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (frame_tick && (state == PLAY)),
    .q     (lfsr_q)
  );

  // Next-frame physics, scroll, scoring and collision for PLAY
  logic signed [4:0]  vel_nx;
  logic signed [10:0] bird_nx;
  logic        [9:0]  bird_clamp;
  logic        [9:0]  px_nx  [2];
  logic        [9:0]  gap_nx [2];
  logic        [7:0]  score_nx;
  logic               hit;

  always_comb begin
    vel_nx   = flap_eff ? VEL_FLAP : ((vel >= VEL_MAX) ? VEL_MAX : vel + 5'sd1);
    bird_nx  = $signed({1'b0, bird_y}) + $signed({{6{vel_nx[4]}}, vel_nx});
    score_nx = score;
    hit      = (bird_nx < 11'sd0) || (bird_nx + S_BIRD_SZ > S_GROUND);
    for (int i = 0; i < 2; i++) begin
      if (pipe_x[i] < 10'(SCROLL)) begin
        px_nx[i]  = 10'(SCREEN_W);
        gap_nx[i] = GAP_MIN + {2'b00, lfsr_q};
      end else begin
        px_nx[i]  = pipe_x[i] - 10'(SCROLL);
        gap_nx[i] = gap_top[i];
      end
      // Right edge crossing the bird's left edge on this tick scores one.
      if (({1'b0, pipe_x[i]} + 11'(PIPE_W) > 11'(BIRD_X)) &&
          ({1'b0, px_nx[i]} + 11'(PIPE_W) <= 11'(BIRD_X)) && (score_nx != 8'hFF))
        score_nx = score_nx + 8'd1;
      if (({1'b0, px_nx[i]} < 11'(BIRD_X + BIRD_SZ)) &&
          ({1'b0, px_nx[i]} + 11'(PIPE_W) > 11'(BIRD_X)) &&
          ((bird_nx < $signed({1'b0, gap_nx[i]})) ||
           (bird_nx + S_BIRD_SZ > $signed({1'b0, gap_nx[i]}) + S_GAP_H)))
        hit = 1'b1;
    end
    bird_clamp = (bird_nx < 11'sd0) ? 10'd0 : bird_nx[9:0];
  end

  // Frame-rate state update
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // Levels already high at reset release are not treated as edges.
      vsync_d    <= 1'b1;
      flap_d     <= 1'b1;
      flap_pend  <= 1'b0;
      state      <= IDLE;
      bird_y     <= BIRD_Y_RST;
      vel        <= 5'sd0;
      pipe_x[0]  <= PIPE0_X_RST;
      pipe_x[1]  <= PIPE1_X_RST;
      gap_top[0] <= GAP_TOP_RST;
      gap_top[1] <= GAP_TOP_RST;
      score      <= 8'd0;
      game_over  <= 1'b0;
    end else begin
      vsync_d <= vsync;
      flap_d  <= flap;
      if (frame_tick)     flap_pend <= 1'b0;
      else if (flap_rise) flap_pend <= 1'b1;
      if (frame_tick) begin
        case (state)
          IDLE: if (flap_eff) begin
            state      <= PLAY;
            bird_y     <= BIRD_Y_RST;
            vel        <= VEL_FLAP;
            score      <= 8'd0;
            pipe_x[0]  <= PIPE0_X_RST;
            pipe_x[1]  <= PIPE1_X_RST;
            gap_top[0] <= GAP_TOP_RST;
            gap_top[1] <= GAP_TOP_RST;
          end
          PLAY: begin
            vel        <= vel_nx;
            bird_y     <= bird_clamp;
            pipe_x[0]  <= px_nx[0];
            pipe_x[1]  <= px_nx[1];
            gap_top[0] <= gap_nx[0];
            gap_top[1] <= gap_nx[1];
            score      <= score_nx;
            if (hit) begin
              state     <= DEAD;
              game_over <= 1'b1;
            end
          end
          DEAD: if (flap_eff) begin
            state      <= IDLE;
            bird_y     <= BIRD_Y_RST;
            vel        <= 5'sd0;
            pipe_x[0]  <= PIPE0_X_RST;
            pipe_x[1]  <= PIPE1_X_RST;
            gap_top[0] <= GAP_TOP_RST;
            gap_top[1] <= GAP_TOP_RST;
            score      <= 8'd0;
            game_over  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Pixel render, registered one clock after the scan position
  logic [10:0] x11, y11;
  logic        in_bird, in_pipe;
  logic [2:0]  pix;

  always_comb begin
    x11     = {1'b0, x_pos};
    y11     = {1'b0, y_pos};
    in_bird = (x11 >= 11'(BIRD_X)) && (x11 < 11'(BIRD_X + BIRD_SZ)) &&
              (y11 >= {1'b0, bird_y}) && (y11 < {1'b0, bird_y} + 11'(BIRD_SZ));
    in_pipe = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if ((x11 >= {1'b0, pipe_x[i]}) && (x11 < {1'b0, pipe_x[i]} + 11'(PIPE_W)) &&
          ((y11 < {1'b0, gap_top[i]}) || (y11 >= {1'b0, gap_top[i]} + 11'(GAP_H))))
        in_pipe = 1'b1;
    end
    if ((x11 >= 11'(SCREEN_W)) || (y11 >= 11'(SCREEN_H))) pix = COL_BLANK;
    else if (in_bird)                                     pix = COL_BIRD;
    else if (in_pipe)                                     pix = COL_PIPE;
    else if (y11 >= 11'(GROUND_Y))                        pix = COL_GROUND;
    else                                                  pix = COL_SKY;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rgb <= COL_BLANK;
    else        rgb <= pix;
  end

endmodule

// File: tb/tb_bird_scene.sv
module tb_bird_scene;

  logic       clk = 1'b0;
  logic       n_rst, flap, vsync;
  logic [9:0] x_pos, y_pos;
  logic [2:0] rgb;
  logic [7:0] score;
  logic       game_over;

  bird_scene dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .flap      (flap),
    .vsync     (vsync),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .rgb       (rgb),
    .score     (score),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference game model: state 0 idle, 1 play, 2 dead
  int m_state, m_by, m_vel, m_lfsr, m_score, m_over;
  int m_px [2];
  int m_gap[2];
  bit m_pend;

  function automatic int lfsr_next(input int v);
    logic [7:0] b;
    b = v[7:0];
    return int'({b[6:0], ^(b & 8'hB8)});
  endfunction

  task automatic model_reset(input bit keep_lfsr);
    m_state = 0; m_by = 232; m_vel = 0; m_score = 0; m_over = 0;
    m_px[0] = 640; m_px[1] = 960; m_gap[0] = 160; m_gap[1] = 160;
    if (!keep_lfsr) begin m_lfsr = 'hB4; m_pend = 0; end
  endtask

  task automatic model_tick();
    bit eff, dead;
    int old;
    eff = m_pend; m_pend = 0;
    if (m_state == 0) begin
      if (eff) begin model_reset(1); m_state = 1; m_vel = -8; end
    end else if (m_state == 1) begin
      m_vel = eff ? -8 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
      m_by  = m_by + m_vel;
      for (int i = 0; i < 2; i++) begin
        old = m_px[i];
        if (old < 2) begin m_px[i] = 640; m_gap[i] = 48 + m_lfsr; end
        else m_px[i] = old - 2;
        if (old + 40 > 160 && m_px[i] + 40 <= 160 && m_score < 255) m_score++;
      end
      m_lfsr = lfsr_next(m_lfsr);
      dead = 0;
      if (m_by < 0) begin dead = 1; m_by = 0; end
      if (m_by + 16 > 448) dead = 1;
      for (int i = 0; i < 2; i++)
        if (m_px[i] < 176 && m_px[i] + 40 > 160 &&
            (m_by < m_gap[i] || m_by + 16 > m_gap[i] + 120)) dead = 1;
      if (dead) begin m_state = 2; m_over = 1; end
    end else if (eff) begin
      model_reset(1);
    end
  endtask

  function automatic logic [2:0] exp_pix(input int x, input int y);
    if (x >= 640 || y >= 480) return 3'b000;
    if (x >= 160 && x < 176 && y >= m_by && y < m_by + 16) return 3'b110;
    for (int i = 0; i < 2; i++)
      if (x >= m_px[i] && x < m_px[i] + 40 && (y < m_gap[i] || y >= m_gap[i] + 120))
        return 3'b010;
    if (y >= 448) return 3'b100;
    return 3'b011;
  endfunction

  task automatic scan(input int x, input int y, output logic [2:0] got);
    @(negedge clk); x_pos = 10'(x); y_pos = 10'(y);
    @(negedge clk); got = rgb;
  endtask

  // One frame: optional flap (separate cycle or same cycle as the vsync rise)
  task automatic frame(input bit fl, input bit same);
    if (fl && !same) begin
      @(negedge clk); flap = 1'b1;
      @(negedge clk); flap = 1'b0; m_pend = 1;
    end
    @(negedge clk); vsync = 1'b1;
    if (fl && same) begin flap = 1'b1; m_pend = 1; end
    @(posedge clk); model_tick();
    @(negedge clk); vsync = 1'b0; flap = 1'b0;
  endtask

  task automatic random_scans(input int n, input string tag);
    logic [2:0] got, want;
    int x, y;
    for (int k = 0; k < n; k++) begin
      if (k % 3 == 0) begin x = 150 + $urandom_range(0, 35); y = m_by - 4 + $urandom_range(0, 24); end
      else begin x = $urandom_range(0, 700); y = $urandom_range(0, 500); end
      want = exp_pix(x, y);
      scan(x, y, got);
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s_pix (%0d,%0d): got %b want %b", tag, x, y, got, want);
      end
    end
  endtask

  task automatic test_reset();
    logic [2:0] got;
    n_rst = 1'b0; flap = 1'b0; vsync = 1'b0; x_pos = '0; y_pos = '0;
    model_reset(0);
    #12;
    n_tests++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL reset_rgb: got %b want 000", rgb); end
    n_tests++; if (score !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", score); end
    n_tests++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_over: got %b want 0", game_over); end
    @(negedge clk); n_rst = 1'b1;
    scan(100, 100, got);
    n_tests++; if (got !== exp_pix(100, 100)) begin n_fail++; $display("FAIL reset_sky: got %b want %b", got, exp_pix(100, 100)); end
    scan(165, 240, got);
    n_tests++; if (got !== exp_pix(165, 240)) begin n_fail++; $display("FAIL reset_bird: got %b want %b", got, exp_pix(165, 240)); end
    scan(700, 10, got);
    n_tests++; if (got !== exp_pix(700, 10)) begin n_fail++; $display("FAIL reset_blank: got %b want %b", got, exp_pix(700, 10)); end
    scan(300, 460, got);
    n_tests++; if (got !== exp_pix(300, 460)) begin n_fail++; $display("FAIL reset_ground: got %b want %b", got, exp_pix(300, 460)); end
    random_scans(15, "idle");
  endtask

  task automatic test_start();
    for (int t = 1; t <= 3; t++) begin
      frame(t == 1, 1'b0);
      @(negedge clk);
      n_tests++;
      if (int'(dut.bird_y) !== m_by) begin n_fail++; $display("FAIL start_bird_y tick %0d: got %0d want %0d", t, dut.bird_y, m_by); end
      n_tests++;
      if (int'($signed(dut.vel)) !== m_vel) begin n_fail++; $display("FAIL start_vel tick %0d: got %0d want %0d", t, $signed(dut.vel), m_vel); end
    end
    n_tests++;
    if (game_over !== 1'b0) begin n_fail++; $display("FAIL start_over: got %b want 0", game_over); end
    random_scans(10, "start");
  endtask

  task automatic test_same_cycle();
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b1);
    @(negedge clk);
    n_tests++;
    if (int'($signed(dut.vel)) !== m_vel) begin n_fail++; $display("FAIL same_cycle_vel: got %0d want %0d", $signed(dut.vel), m_vel); end
    n_tests++;
    if (int'(dut.bird_y) !== m_by) begin n_fail++; $display("FAIL same_cycle_bird_y: got %0d want %0d", dut.bird_y, m_by); end
  endtask

  task automatic test_long_play();
    int tgt, sel;
    bit fl;
    for (int f = 0; f < 340; f++) begin
      sel = (m_px[0] + 40 > 160 && (m_px[0] < m_px[1] || m_px[1] + 40 <= 160)) ? 0 : 1;
      tgt = m_gap[sel] + 52;
      fl  = (m_state != 1) || ((m_by > tgt + 10) && (m_vel >= 0 || m_by > tgt + 40));
      frame(fl, 1'($urandom_range(0, 1)));
      @(negedge clk);
      n_tests++; if (int'(dut.bird_y) !== m_by) begin n_fail++; $display("FAIL play_bird_y f%0d: got %0d want %0d", f, dut.bird_y, m_by); end
      n_tests++; if (int'(dut.pipe_x[0]) !== m_px[0]) begin n_fail++; $display("FAIL play_pipe0 f%0d: got %0d want %0d", f, dut.pipe_x[0], m_px[0]); end
      n_tests++; if (int'(dut.pipe_x[1]) !== m_px[1]) begin n_fail++; $display("FAIL play_pipe1 f%0d: got %0d want %0d", f, dut.pipe_x[1], m_px[1]); end
      n_tests++; if (int'(dut.gap_top[0]) !== m_gap[0]) begin n_fail++; $display("FAIL play_gap0 f%0d: got %0d want %0d", f, dut.gap_top[0], m_gap[0]); end
      n_tests++; if (int'(score) !== m_score) begin n_fail++; $display("FAIL play_score f%0d: got %0d want %0d", f, score, m_score); end
      n_tests++; if (int'(game_over) !== m_over) begin n_fail++; $display("FAIL play_over f%0d: got %0d want %0d", f, game_over, m_over); end
      if (f % 20 == 7) random_scans(6, "play");
    end
  endtask

  task automatic test_reset_mid_play();
    logic [2:0] got;
    if (m_state != 1) begin
      frame(1'b1, 1'b0);
      if (m_state != 1) frame(1'b1, 1'b0);
      frame(1'b0, 1'b0);
    end
    scan(100, 100, got);
    @(posedge clk);
    #($urandom_range(1, 3));
    n_rst = 1'b0;
    model_reset(0);
    #1;
    n_tests++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL midrst_rgb: got %b want 000", rgb); end
    n_tests++; if (score !== 8'd0) begin n_fail++; $display("FAIL midrst_score: got %0d want 0", score); end
    n_tests++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL midrst_over: got %b want 0", game_over); end
    n_tests++; if (int'(dut.pipe_x[0]) !== m_px[0]) begin n_fail++; $display("FAIL midrst_pipe0: got %0d want %0d", dut.pipe_x[0], m_px[0]); end
    n_tests++; if (int'(dut.pipe_x[1]) !== m_px[1]) begin n_fail++; $display("FAIL midrst_pipe1: got %0d want %0d", dut.pipe_x[1], m_px[1]); end
    n_tests++; if (int'(dut.bird_y) !== m_by) begin n_fail++; $display("FAIL midrst_bird_y: got %0d want %0d", dut.bird_y, m_by); end
    @(negedge clk); n_rst = 1'b1;
    random_scans(6, "postrst");
  endtask

  task automatic test_fall_dead();
    int saved, tick;
    bit died;
    frame(1'b1, 1'b0);
    died = 0;
    tick = 0;
    while (!died && tick < 80) begin
      frame(1'b0, 1'b0);
      @(negedge clk);
      tick++;
      n_tests++; if (int'(game_over) !== m_over) begin n_fail++; $display("FAIL fall_over t%0d: got %0d want %0d", tick, game_over, m_over); end
      n_tests++; if (int'(dut.bird_y) !== m_by) begin n_fail++; $display("FAIL fall_bird_y t%0d: got %0d want %0d", tick, dut.bird_y, m_by); end
      died = (m_state == 2);
    end
    n_tests++;
    if (!died || game_over !== 1'b1) begin n_fail++; $display("FAIL fall_dead: got game_over %b after %0d ticks want 1", game_over, tick); end
    saved = int'(dut.bird_y);
    random_scans(6, "dead");
    for (int t = 0; t < 3; t++) begin
      frame(1'b0, 1'b0);
      @(negedge clk);
      n_tests++; if (int'(dut.bird_y) !== saved || saved !== m_by) begin n_fail++; $display("FAIL frozen_bird_y: got %0d want %0d", dut.bird_y, m_by); end
      n_tests++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL frozen_over: got %b want 1", game_over); end
    end
    frame(1'b1, 1'b0);
    @(negedge clk);
    n_tests++; if (int'(dut.bird_y) !== m_by) begin n_fail++; $display("FAIL restart_bird_y: got %0d want %0d", dut.bird_y, m_by); end
    n_tests++; if (int'(game_over) !== m_over) begin n_fail++; $display("FAIL restart_over: got %0d want %0d", game_over, m_over); end
    n_tests++; if (int'(score) !== m_score) begin n_fail++; $display("FAIL restart_score: got %0d want %0d", score, m_score); end
    random_scans(8, "restart");
  endtask

  initial begin
    test_reset();
    test_start();
    test_same_cycle();
    test_long_play();
    test_reset_mid_play();
    test_fall_dead();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
